// File: rtl/armaria_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, default reset PC
// and the halfword-select helper used when splitting a memory word into two instructions.
package armaria_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // [15:0] is the lower (earlier) instruction of a fetched word.
  function automatic logic [15:0] hw_sel(input logic [31:0] wrd, input logic upper);
    return upper ? wrd[31:16] : wrd[15:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {instruction, pc} entries with a dual push (lower then upper halfword), pop and flush.
// Latency: a push is visible at the head on the next cycle; the head is read straight from storage.
// Backpressure: none internally; the caller keeps two slots free before issuing a fetch.
module fetch_fifo
  import armaria_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = 16,
  parameter int AW    = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush_i,
  input  logic                           push_lo_i,
  input  logic                           push_hi_i,
  input  logic                           pop_i,
  input  logic [IW-1:0]                  lo_instr_i,
  input  logic [AW-1:0]                  lo_pc_i,
  input  logic [IW-1:0]                  hi_instr_i,
  input  logic [AW-1:0]                  hi_pc_i,
  output logic                           head_vld_o,
  output logic [IW-1:0]                  head_instr_o,
  output logic [AW-1:0]                  head_pc_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = IW + AW;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, hi_slot;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  // The upper halfword lands behind the lower one when both arrive together.
  assign hi_slot = push_lo_i ? wr_ptr_q + PW'(1) : wr_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push_lo_i) + PW'(push_hi_i);
      rd_ptr_d = rd_ptr_q + PW'(pop_ok);
      count_d  = count_q + CW'(push_lo_i) + CW'(push_hi_i) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!flush_i) begin
      if (push_lo_i) mem_q[wr_ptr_q] <= {lo_instr_i, lo_pc_i};
      if (push_hi_i) mem_q[hi_slot]  <= {hi_instr_i, hi_pc_i};
    end
  end

  assign head_vld_o   = (count_q != '0);
  assign head_instr_o = head_vld_o ? mem_q[rd_ptr_q][EW-1:AW] : '0;
  assign head_pc_o    = head_vld_o ? mem_q[rd_ptr_q][AW-1:0]  : '0;
  assign count_o      = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches 32-bit words, splits them into 16-bit instructions and presents the prefetch head to Control.
// Latency: mem_ack in cycle N gives instruction_valid in N+1; a branch flushes so valid drops the next cycle.
// Backpressure: a fetch is issued only with two free slots; optional FETCH_PERF_COUNT_EN adds perf counters.
module instruction_fetch_unit
  import armaria_fetch_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int ADDR_WIDTH        = 32,
  parameter int FIFO_DEPTH        = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic                         mem_req,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic                         mem_ack,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  input  logic                         branch_taken,
  input  logic [ADDR_WIDTH-1:0]        branch_target,
  input  logic                         consume,
  output logic [INSTRUCTION_WIDTH-1:0] Instruction,
  output logic                         instruction_valid,
  output logic [ADDR_WIDTH-1:0]        instruction_pc
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [15:0]                  fetched_count,
  output logic [15:0]                  flush_count
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] HALF_MASK = ~ADDR_WIDTH'(1);

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] fetch_ptr_q;
  logic                  mem_req_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;

  logic [CNT_W-1:0]      fifo_count;
  logic                  room_ok, accept, fifo_pop, push_lo, push_hi;

  assign room_ok  = (fifo_count <= CNT_W'(FIFO_DEPTH - 2));
  // Branch wins over both an arriving word and a consume in the same cycle.
  assign accept   = (state_q == REQ) && mem_ack && !branch_taken;
  assign push_hi  = accept;
  assign push_lo  = accept && !fetch_ptr_q[1];
  assign fifo_pop = consume && instruction_valid && !branch_taken;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fetch_ptr_q <= RESET_PC;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= RESET_PC & WORD_MASK;
    end else begin
      case (state_q)
        IDLE: begin
          if (branch_taken) begin
            fetch_ptr_q <= branch_target & HALF_MASK;
          end else if (room_ok) begin
            state_q    <= REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_ptr_q & WORD_MASK;
          end
        end
        REQ: begin
          if (branch_taken) begin
            fetch_ptr_q <= branch_target & HALF_MASK;
            if (mem_ack) begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
            end else begin
              // The request is already on the bus; its data must be absorbed and dropped.
              state_q <= DISCARD;
            end
          end else if (mem_ack) begin
            fetch_ptr_q <= mem_addr_q + ADDR_WIDTH'(4);
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
          end
        end
        DISCARD: begin
          if (branch_taken) fetch_ptr_q <= branch_target & HALF_MASK;
          if (mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .IW    (INSTRUCTION_WIDTH),
    .AW    (ADDR_WIDTH)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .flush_i      (branch_taken),
    .push_lo_i    (push_lo),
    .push_hi_i    (push_hi),
    .pop_i        (fifo_pop),
    .lo_instr_i   (INSTRUCTION_WIDTH'(hw_sel(32'(mem_rdata), 1'b0))),
    .lo_pc_i      (mem_addr_q),
    .hi_instr_i   (INSTRUCTION_WIDTH'(hw_sel(32'(mem_rdata), 1'b1))),
    .hi_pc_i      (mem_addr_q + ADDR_WIDTH'(2)),
    .head_vld_o   (instruction_valid),
    .head_instr_o (Instruction),
    .head_pc_o    (instruction_pc),
    .count_o      (fifo_count)
  );

`ifdef FETCH_PERF_COUNT_EN
  logic [15:0] fetched_q, fetched_d, flush_q, flush_d;

  always_comb begin
    fetched_d = fetched_q;
    flush_d   = flush_q;
    if (fifo_pop && (fetched_q != 16'hFFFF))   fetched_d = fetched_q + 16'd1;
    if (branch_taken && (flush_q != 16'hFFFF)) flush_d   = flush_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetched_q <= '0;
      flush_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      flush_q   <= flush_d;
    end
  end

  assign fetched_count = fetched_q;
  assign flush_count   = flush_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_instruction_fetch_unit;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        consume = 1'b0;
  logic [15:0] Instruction;
  logic        instruction_valid;
  logic [31:0] instruction_pc;
`ifdef FETCH_PERF_COUNT_EN
  logic [15:0] fetched_count, flush_count;
`endif

  always #5 clock = ~clock;

  instruction_fetch_unit dut (
    .clock             (clock),
    .reset             (reset),
    .mem_req           (mem_req),
    .mem_addr          (mem_addr),
    .mem_ack           (mem_ack),
    .mem_rdata         (mem_rdata),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .consume           (consume),
    .Instruction       (Instruction),
    .instruction_valid (instruction_valid),
    .instruction_pc    (instruction_pc)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .fetched_count     (fetched_count),
    .flush_count       (flush_count)
`endif
  );

  typedef struct packed {
    logic [15:0] ins;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fptr, m_req_addr;
  bit          m_req, m_stale;
  int          m_fetched, m_flushes;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          mwait   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid", {63'd0, instruction_valid}, {63'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("instr", {48'd0, Instruction}, {48'd0, mq[0].ins});
      chk("pc", {32'd0, instruction_pc}, {32'd0, mq[0].pc});
    end
    chk("mem_req", {63'd0, mem_req}, {63'd0, m_req});
    if (m_req) chk("mem_addr", {32'd0, mem_addr}, {32'd0, m_req_addr});
`ifdef FETCH_PERF_COUNT_EN
    chk("fetched_count", {48'd0, fetched_count}, 64'(m_fetched));
    chk("flush_count", {48'd0, flush_count}, 64'(m_flushes));
`endif
  endtask

  // Reference behaviour for one clock edge given this cycle's inputs.
  task automatic model_update(input bit c, input bit b, input logic [31:0] t,
                              input bit a, input logic [31:0] d);
    bit   pop, take;
    ent_t e;
    pop  = c && (mq.size() != 0) && !b;
    take = 0;
    if (b && m_flushes < 65535) m_flushes++;
    if (pop && m_fetched < 65535) m_fetched++;
    if (!m_req) begin
      if (b) m_fptr = t & ~32'd1;
      else if (DEPTH - mq.size() >= 2) begin
        m_req      = 1;
        m_req_addr = m_fptr & ~32'd3;
        m_stale    = 0;
      end
    end else begin
      take = a && !b && !m_stale;
      if (a) m_req = 0;
      if (b) begin
        m_fptr  = t & ~32'd1;
        m_stale = 1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (b) mq.delete();
    if (take) begin
      if (!m_fptr[1]) begin
        e.ins = d[15:0];
        e.pc  = m_req_addr;
        mq.push_back(e);
      end
      e.ins = d[31:16];
      e.pc  = m_req_addr + 32'd2;
      mq.push_back(e);
      m_fptr = m_req_addr + 32'd4;
    end
  endtask

  task automatic cyc(input bit c, input bit b, input logic [31:0] t,
                     input bit a, input logic [31:0] d);
    check_outputs();
    consume       = c;
    branch_taken  = b;
    branch_target = t;
    mem_ack       = a;
    mem_rdata     = d;
    model_update(c, b, t, a, d);
  endtask

  task automatic tick(input bit c, input bit b, input logic [31:0] t,
                      input bit a, input logic [31:0] d);
    @(negedge clock);
    cyc(c, b, t, a, d);
  endtask

  // Memory responds to a visible request after a random 0..3 cycle delay; rare stray acks probe IDLE.
  task automatic auto_cyc(input bit c, input bit b, input logic [31:0] t);
    bit          a;
    logic [31:0] d;
    @(negedge clock);
    a = 0;
    d = $urandom;
    if (mem_req) begin
      if (mwait == 0) begin
        a     = 1;
        mwait = $urandom_range(0, 3);
      end else mwait--;
    end else if ($urandom_range(0, 49) == 0) a = 1;
    cyc(c, b, t, a, d);
  endtask

  task automatic do_reset(input bit ack_on_release);
    @(negedge clock);
    reset = 1'b0;
    consume = 0; branch_taken = 0; branch_target = '0; mem_ack = 0; mem_rdata = '0;
    mq.delete();
    m_req = 0; m_stale = 0; m_fptr = 32'h0; m_req_addr = 32'h0;
    m_fetched = 0; m_flushes = 0; mwait = 0;
    @(negedge clock);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    chk("rst_valid", {63'd0, instruction_valid}, 64'd0);
    chk("rst_instr", {48'd0, Instruction}, 64'd0);
    chk("rst_pc", {32'd0, instruction_pc}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    cyc(0, 0, 32'h0, ack_on_release, 32'h5A5A_A5A5);
  endtask

  initial begin
    // Basic fetch: one word splits into two instructions in order.
    do_reset(0);
    tick(0, 0, 0, 1, 32'hBBBB_AAAA);
    @(negedge clock);
    chk("first_instr", {48'd0, Instruction}, 64'hAAAA);
    chk("first_pc", {32'd0, instruction_pc}, 64'h0);
    cyc(1, 0, 0, 0, 0);
    @(negedge clock);
    chk("second_instr", {48'd0, Instruction}, 64'hBBBB);
    chk("second_pc", {32'd0, instruction_pc}, 64'h2);
    cyc(0, 0, 0, 0, 0);

    // Full buffer: a third word is not accepted and no fetch issues until two slots free.
    do_reset(0);
    tick(0, 0, 0, 1, 32'h2222_1111);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 32'h4444_3333);
    tick(0, 0, 0, 1, 32'h6666_5555);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("full_no_req", {63'd0, mem_req}, 64'd0);
      cyc(0, 0, 0, 0, 0);
    end
    @(negedge clock);
    chk("full_head", {48'd0, Instruction}, 64'h1111);
    cyc(1, 0, 0, 0, 0);
    @(negedge clock);
    chk("one_free_no_req", {63'd0, mem_req}, 64'd0);
    cyc(1, 0, 0, 0, 0);
    @(negedge clock);
    chk("gate_on_old_count", {63'd0, mem_req}, 64'd0);
    cyc(0, 0, 0, 0, 0);
    @(negedge clock);
    chk("two_free_req", {63'd0, mem_req}, 64'd1);
    chk("two_free_addr", {32'd0, mem_addr}, 64'h8);
    cyc(0, 0, 0, 0, 0);

    // Branch while a request is outstanding: its data is dropped, refetch from the odd halfword.
    do_reset(0);
    tick(0, 1, 32'h102, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 32'hDEAD_BEEF);
    tick(0, 0, 0, 0, 0);
    @(negedge clock);
    chk("redir_req", {63'd0, mem_req}, 64'd1);
    chk("redir_addr", {32'd0, mem_addr}, 64'h100);
    cyc(0, 0, 0, 1, 32'hCAFE_F00D);
    @(negedge clock);
    chk("redir_instr", {48'd0, Instruction}, 64'hCAFE);
    chk("redir_pc", {32'd0, instruction_pc}, 64'h102);
    cyc(1, 0, 0, 0, 0);

    // Branch and ack in the same cycle: branch wins.
    do_reset(0);
    tick(0, 1, 32'h206, 1, 32'h1234_5678);
    @(negedge clock);
    chk("br_ack_empty", {63'd0, instruction_valid}, 64'd0);
    cyc(0, 0, 0, 0, 0);
    @(negedge clock);
    chk("br_ack_addr", {32'd0, mem_addr}, 64'h204);
    cyc(0, 0, 0, 1, 32'h9999_8888);
    @(negedge clock);
    chk("br_ack_instr", {48'd0, Instruction}, 64'h9999);
    cyc(0, 0, 0, 0, 0);

    // Reset during an outstanding request; the late ack is ignored.
    do_reset(0);
    do_reset(1);
    @(negedge clock);
    chk("rst_mid_valid", {63'd0, instruction_valid}, 64'd0);
    chk("rst_mid_addr", {32'd0, mem_addr}, 64'h0);
    cyc(0, 0, 0, 1, 32'h7777_6666);
    @(negedge clock);
    chk("rst_mid_instr", {48'd0, Instruction}, 64'h6666);
    chk("rst_mid_pc", {32'd0, instruction_pc}, 64'h0);
    cyc(0, 0, 0, 0, 0);

    // Randomized traffic, including targets near the top of the address space.
    do_reset(0);
    for (int i = 0; i < 3000; i++) begin
      bit          c, b;
      logic [31:0] t;
      c = ($urandom_range(0, 9) < 6);
      b = ($urandom_range(0, 19) == 0);
      t = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                       : ($urandom & 32'h3FF);
      auto_cyc(c, b, t);
    end

`ifdef FETCH_PERF_COUNT_EN
    do_reset(0);
    for (int i = 0; i < 400 && m_fetched < 5; i++) auto_cyc(m_fetched < 5, 0, 0);
    auto_cyc(0, 1, 32'h40);
    auto_cyc(0, 1, 32'h80);
    @(negedge clock);
    chk("perf_fetched", {48'd0, fetched_count}, 64'd5);
    chk("perf_flush", {48'd0, flush_count}, 64'd2);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) auto_cyc(0, 1, $urandom & 32'hFFE);
    @(negedge clock);
    chk("perf_flush_sat", {48'd0, flush_count}, 64'hFFFF);
`endif

    @(negedge clock);
    check_outputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
